// File: rtl/i2s_master_tx.sv
// i2s_master_tx
// I2S bus-master transmitter. Derives SCLK and LRCK from clk_12M and serialises
// one stereo pair per frame, MSB first with the standard one-bit delay after
// each LRCK edge. A one-entry valid/ready buffer decouples the sample source
// from the frame timing. sck, ws and sda come from the same register stage, so
// ws/sda always change together with the falling SCLK edge.
module i2s_master_tx #(
    parameter int DATA_WIDTH = 16,
    parameter int SLOT_WIDTH = 32,
    parameter int BCLK_DIV   = 2
) (
    input  logic                  clk_12M,
    input  logic                  rst,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] ldata,
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic                  din_valid,
    output logic                  din_ready,
    output logic                  sck,
    output logic                  ws,
    output logic                  sda,
    output logic                  frame_start,
    output logic                  underrun
);

    localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam int BIT_W = $clog2(2 * SLOT_WIDTH);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(2 * SLOT_WIDTH - 1);
    localparam logic [BIT_W-1:0] SLOT_LEN = BIT_W'(SLOT_WIDTH);
    localparam logic [BIT_W-1:0] DATA_LEN = BIT_W'(DATA_WIDTH);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t           state_reg, state_next;
    logic [DIV_W-1:0] div_cnt_reg, div_cnt_next;
    logic [BIT_W-1:0] bit_cnt_reg, bit_cnt_next;
    logic             sck_reg, sck_next;
    logic             ws_reg, ws_next;
    logic             sda_reg, sda_next;
    logic             full_reg, full_next;

    // Frame control strobes shared by both channels.
    logic             load;       // shift registers take the buffer this cycle
    logic             wr;         // accepted valid/ready transfer
    logic             fall;       // sck goes 1->0 at the end of this cycle
    logic [BIT_W-1:0] slot_pos;   // position inside the current slot
    logic [1:0]       shift_en;   // [0] = left channel, [1] = right channel
    logic [1:0]       sh_msb;     // current MSB of each channel shift register

    // Handshake and pulses. A pair offered in a load cycle is accepted because
    // the old contents leave the buffer in that same cycle.
    assign din_ready   = ~full_reg | load;
    assign wr          = din_valid & din_ready;
    assign frame_start = load & ~rst;
    assign underrun    = load & ~full_reg & ~rst;

    assign sck = sck_reg;
    assign ws  = ws_reg;
    assign sda = sda_reg;

    // Next-state logic: divider, bit counter, frame sequencing and serial outputs.
    always_comb begin
        state_next   = state_reg;
        div_cnt_next = div_cnt_reg;
        bit_cnt_next = bit_cnt_reg;
        sck_next     = sck_reg;
        ws_next      = ws_reg;
        sda_next     = sda_reg;
        load         = 1'b0;
        fall         = 1'b0;
        shift_en     = 2'b00;
        slot_pos     = '0;

        case (state_reg)
            ST_IDLE: begin
                div_cnt_next = '0;
                bit_cnt_next = '0;
                sck_next     = 1'b0;
                ws_next      = 1'b0;
                sda_next     = 1'b0;
                // The first enabled cycle loads the first frame; clocks start next cycle.
                if (en) begin
                    load       = 1'b1;
                    state_next = ST_RUN;
                end
            end

            ST_RUN: begin
                if (div_cnt_reg == DIV_LAST) begin
                    div_cnt_next = '0;
                    sck_next     = ~sck_reg;
                    fall         = sck_reg;
                end else begin
                    div_cnt_next = div_cnt_reg + 1'b1;
                end

                if (fall) begin
                    if (bit_cnt_reg == BIT_LAST) begin
                        // Frame boundary: either start the next frame or park.
                        bit_cnt_next = '0;
                        ws_next      = 1'b0;
                        sda_next     = 1'b0;
                        if (en) begin
                            load = 1'b1;
                        end else begin
                            state_next = ST_IDLE;
                        end
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 1'b1;
                        ws_next      = (bit_cnt_next >= SLOT_LEN);
                        slot_pos     = ws_next ? (bit_cnt_next - SLOT_LEN) : bit_cnt_next;
                        // Position 0 is the one-bit delay; data occupies 1..DATA_WIDTH.
                        if ((slot_pos != '0) && (slot_pos <= DATA_LEN)) begin
                            shift_en = ws_next ? 2'b10 : 2'b01;
                            sda_next = ws_next ? sh_msb[1] : sh_msb[0];
                        end else begin
                            sda_next = 1'b0;
                        end
                    end
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Buffer occupancy: a load empties it, an accepted write fills it.
    always_comb begin
        full_next = full_reg;
        if (load) begin
            full_next = wr;
        end else if (wr) begin
            full_next = 1'b1;
        end
    end

    // Control and output registers.
    always_ff @(posedge clk_12M) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            div_cnt_reg <= '0;
            bit_cnt_reg <= '0;
            sck_reg     <= 1'b0;
            ws_reg      <= 1'b0;
            sda_reg     <= 1'b0;
            full_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            div_cnt_reg <= div_cnt_next;
            bit_cnt_reg <= bit_cnt_next;
            sck_reg     <= sck_next;
            ws_reg      <= ws_next;
            sda_reg     <= sda_next;
            full_reg    <= full_next;
        end
    end

    // Per-channel datapath: holding buffer plus MSB-first shift register.
    // Channel 0 is left (slot 0), channel 1 is right (slot 1).
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ch
            logic [DATA_WIDTH-1:0] din_sel;
            logic [DATA_WIDTH-1:0] buf_reg, buf_next;
            logic [DATA_WIDTH-1:0] sh_reg, sh_next;

            assign din_sel    = (gi == 0) ? ldata : rdata;
            assign sh_msb[gi] = sh_reg[DATA_WIDTH-1];

            // Buffer captures on an accepted transfer and otherwise holds.
            always_comb begin
                buf_next = buf_reg;
                if (wr) begin
                    buf_next = din_sel;
                end
            end

            // Shift register: parallel load at frame start (zeros on underrun),
            // shift left on each data position of its own slot.
            always_comb begin
                sh_next = sh_reg;
                if (load) begin
                    sh_next = full_reg ? buf_reg : '0;
                end else if (shift_en[gi]) begin
                    sh_next = {sh_reg[DATA_WIDTH-2:0], 1'b0};
                end
            end

            // Channel registers; reset discards any buffered sample.
            always_ff @(posedge clk_12M) begin
                if (rst) begin
                    buf_reg <= '0;
                    sh_reg  <= '0;
                end else begin
                    buf_reg <= buf_next;
                    sh_reg  <= sh_next;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_i2s_master_tx.sv
// tb_i2s_master_tx
// Scoreboard bench: every accepted pair (and every expected underrun frame) is
// queued at drive time; a monitor decodes frames from sck/ws/sda and compares.
module tb_i2s_master_tx;

    logic        clk;
    logic        rst;
    logic        en;
    logic [15:0] ldata;
    logic [15:0] rdata;
    logic        din_valid;
    logic        din_ready;
    logic        sck;
    logic        ws;
    logic        sda;
    logic        frame_start;
    logic        underrun;

    i2s_master_tx #(
        .DATA_WIDTH (16),
        .SLOT_WIDTH (32),
        .BCLK_DIV   (2)
    ) dut (
        .clk_12M     (clk),
        .rst         (rst),
        .en          (en),
        .ldata       (ldata),
        .rdata       (rdata),
        .din_valid   (din_valid),
        .din_ready   (din_ready),
        .sck         (sck),
        .ws          (ws),
        .sda         (sda),
        .frame_start (frame_start),
        .underrun    (underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] l;
        logic [15:0] r;
        logic        und;
    } exp_t;

    exp_t q[$];
    exp_t cur;

    int tests = 0;
    int fails = 0;
    int n_push = 0;
    int frames_done = 0;
    int aborted = 0;

    // Monitor state
    int          cyc = 0;
    logic        active = 1'b0;
    int          k = 0;
    int          p = 0;
    int          last_rise = 0;
    int          bad_ws = 0;
    int          bad_pad = 0;
    int          bad_per = 0;
    int          ws_run = 0;
    logic        sck_prev = 1'b0;
    logic        ws_prev = 1'b0;
    logic [15:0] got_l = '0;
    logic [15:0] got_r = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock of stimulus; inputs change just after the edge, and an
    // accepted pair is queued as the next expected frame.
    task automatic cycle(input logic en_v, input logic v, input logic [15:0] l,
                         input logic [15:0] r, output logic took);
        exp_t e;
        @(posedge clk);
        #1;
        en        = en_v;
        din_valid = v;
        ldata     = l;
        rdata     = r;
        #1;
        took = v && din_ready;
        if (took) begin
            e.l = l;
            e.r = r;
            e.und = 1'b0;
            q.push_back(e);
            n_push++;
            $display("[TB] write L=%h R=%h", l, r);
        end
    endtask

    task automatic run(input logic en_v, input int n);
        logic t;
        for (int i = 0; i < n; i++) cycle(en_v, 1'b0, 16'h0, 16'h0, t);
    endtask

    task automatic expect_underrun_frame();
        exp_t e;
        e.l = '0;
        e.r = '0;
        e.und = 1'b1;
        q.push_back(e);
        n_push++;
    endtask

    task automatic check_quiet(input string tag);
        @(negedge clk);
        check({tag, "_sck"}, 32'(sck), 0);
        check({tag, "_ws"}, 32'(ws), 0);
        check({tag, "_sda"}, 32'(sda), 0);
        check({tag, "_fs"}, 32'(frame_start), 0);
        check({tag, "_und"}, 32'(underrun), 0);
    endtask

    // Frame decoder / scoreboard consumer.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                if (active) aborted++;
                active   = 1'b0;
                ws_run   = 0;
                sck_prev = 1'b0;
                ws_prev  = 1'b0;
            end else begin
                if (frame_start) begin
                    check("prev_frame_done", 32'(active), 0);
                    check("fs_pending", 32'(q.size() > 0), 1);
                    if (q.size() > 0) begin
                        cur = q.pop_front();
                        check("underrun", 32'(underrun), 32'(cur.und));
                        active  = 1'b1;
                        k       = 0;
                        got_l   = '0;
                        got_r   = '0;
                        bad_ws  = 0;
                        bad_pad = 0;
                        bad_per = 0;
                    end else begin
                        active = 1'b0;
                    end
                end
                if (active && sck && !sck_prev) begin
                    p = k % 32;
                    if (ws !== (k >= 32)) bad_ws++;
                    if (p >= 1 && p <= 16) begin
                        if (k < 32) got_l = {got_l[14:0], sda};
                        else        got_r = {got_r[14:0], sda};
                    end else if (sda !== 1'b0) begin
                        bad_pad++;
                    end
                    if (k > 0 && (cyc - last_rise) != 4) bad_per++;
                    last_rise = cyc;
                    k++;
                    if (k == 64) begin
                        $display("[TB] frame %0d L=%h R=%h und=%0b", frames_done, got_l, got_r, cur.und);
                        check("left", 32'(got_l), 32'(cur.l));
                        check("right", 32'(got_r), 32'(cur.r));
                        check("ws_pattern", 32'(bad_ws), 0);
                        check("pad_zero", 32'(bad_pad), 0);
                        check("sck_period", 32'(bad_per), 0);
                        frames_done++;
                        active = 1'b0;
                    end
                end
                if (ws) begin
                    ws_run++;
                end else begin
                    if (ws_prev) check("ws_high_len", 32'(ws_run), 128);
                    ws_run = 0;
                end
                sck_prev = sck;
                ws_prev  = ws;
            end
        end
    end

    // Stimulus
    initial begin
        logic        t;
        int          xfer;
        logic [15:0] kv;

        rst = 1'b1;
        en = 1'b0;
        din_valid = 1'b0;
        ldata = '0;
        rdata = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_quiet("reset");
        check("reset_ready", 32'(din_ready), 1);

        // 1) single pair, one frame, then stop
        cycle(1'b0, 1'b1, 16'hA55A, 16'h1234, t);
        check("t1_accept", 32'(t), 1);
        cycle(1'b0, 1'b0, 16'h0, 16'h0, t);
        check("t1_full", 32'(din_ready), 0);
        run(1'b1, 200);
        run(1'b0, 150);
        check_quiet("t1_idle");

        // 2) enable with empty buffer
        expect_underrun_frame();
        run(1'b1, 200);
        run(1'b0, 150);
        check_quiet("t2_idle");

        // 3) streaming on every din_ready
        kv = 16'h0100;
        cycle(1'b0, 1'b1, kv, kv + 16'd1, t);
        kv = kv + 16'd2;
        xfer = 0;
        for (int i = 0; i < 1200; i++) begin
            cycle(1'b1, 1'b1, kv, kv + 16'd1, t);
            if (t) begin
                xfer++;
                kv = kv + 16'd2;
            end
        end
        check("t3_xfers", 32'(xfer), 5);
        run(1'b0, 150);
        check_quiet("t3_idle");
        check("t3_retained", 32'(din_ready), 0);

        // 4) hold din_valid high with changing data; only load cycles accept
        xfer = 0;
        for (int i = 0; i < 300; i++) begin
            cycle(1'b1, 1'b1, 16'hC000 + 16'(i), 16'hD000 + 16'(i), t);
            if (t) xfer++;
        end
        check("t4_ready_cycles", 32'(xfer), 2);

        // 5) drop en at bit_cnt=40 of the second frame, then re-enable
        run(1'b1, 117);
        run(1'b0, 150);
        check_quiet("t5_idle");
        check("t5_retained", 32'(din_ready), 0);
        for (int i = 0; i < 337; i++) begin
            if (i == 100) cycle(1'b1, 1'b1, 16'h600D, 16'hBEEF, t);
            else          cycle(1'b1, 1'b0, 16'h0, 16'h0, t);
        end

        // 6) reset at bit_cnt=20 of the following frame
        @(posedge clk);
        #1;
        rst = 1'b1;
        en = 1'b0;
        din_valid = 1'b0;
        q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_quiet("t6_reset");
        check("t6_ready", 32'(din_ready), 1);
        run(1'b0, 20);
        check_quiet("t6_idle");
        cycle(1'b0, 1'b1, 16'h7777, 16'h8888, t);
        run(1'b1, 200);
        run(1'b0, 150);
        check_quiet("t6_end");

        check("queue_empty", 32'(q.size()), 0);
        check("frame_count", 32'(frames_done + aborted), 32'(n_push));
        check("aborted", 32'(aborted), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
